// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

  localparam int DIV_W_DEF = 8;
  localparam int DIV_MIN   = 2;

  // Length of the high phase for divisor d; one bit wider than d so d = all-ones cannot overflow.
  function automatic logic [32:0] half_hi(input logic [31:0] d);
    return ({1'b0, d} + 33'd1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter, divided-clock flop and end-of-period tick for the programmable divider.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] d,
  input  logic             apply,
  output logic             clk_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_next;
  logic [DIV_W-1:0] d_last;
  logic [DIV_W:0]   h;
  logic [DIV_W:0]   thr;
  logic             wrap;

  assign d_last   = d - DIV_W'(1);
  assign wrap     = (cnt == d_last);
  assign tick     = en & wrap;
  assign cnt_next = wrap ? '0 : cnt + DIV_W'(1);

  // The output goes high once the count reaches D-H, so odd divisors get the longer high phase.
  assign h   = (DIV_W+1)'(half_hi(32'(d)));
  assign thr = {1'b0, d} - h;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      clk_div <= 1'b0;
    end else if (en) begin
      if (apply) begin
        cnt     <= '0;
        clk_div <= 1'b0;
      end else begin
        cnt     <= cnt_next;
        clk_div <= ({1'b0, cnt_next} >= thr);
      end
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider: divisor load, pending and error handling around clk_div_core.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_RST = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  output logic             clk_div,
  output logic             tick,
  output logic [DIV_W-1:0] div_cur,
  output logic             pend,
  output logic             load_err
);

  if (DIV_RST < DIV_MIN || DIV_RST >= (1 << DIV_W)) begin : g_bad_div_rst
    $error("clk_div_prog: DIV_RST out of range 2..2^DIV_W-1");
  end

  logic [DIV_W-1:0] pend_div;
  logic             accept;
  logic             apply;

  assign accept = div_load && (div_in >= DIV_W'(DIV_MIN));
  // A new divisor only takes over at a period boundary, so the output never shows a runt pulse.
  assign apply  = tick && pend;

  clk_div_core #(
    .DIV_W (DIV_W)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .d       (div_cur),
    .apply   (apply),
    .clk_div (clk_div),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cur  <= DIV_W'(DIV_RST);
      pend_div <= DIV_W'(DIV_RST);
      pend     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_err <= div_load && !accept;
      if (apply) begin
        div_cur <= pend_div;
        pend    <= 1'b0;
      end
      // A load on the boundary cycle becomes pending after the old pending value is applied.
      if (accept) begin
        pend_div <= div_in;
        pend     <= 1'b1;
      end
    end
  end

endmodule
